tinker_fetch: RTL and testbench
===============================

TINKER_FETCH -- requirements
Module: tinker_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h2000, address of first instruction fetched after reset.
REQ-002 SHALL have ports, one per line:
  clk  input  1  sole clock, all state updates on rising edge
  reset  input  1  synchronous, active-high reset
  hlt  input  1  core halt request; stops fetching
  redirect_valid  input  1  control-flow change request
  redirect_pc  input  64  new fetch address
  mem_rd_en  output  1  byte read request to memory_unit
  mem_addr  output  64  byte address of read
  mem_rd_data  input  8  read byte, valid the cycle after mem_rd_en
  inst_valid  output  1  assembled instruction available
  inst_ready  input  1  decode stage accepts instruction
  inst  output  32  assembled instruction word
  inst_pc  output  64  address of inst
  fetch_fault  output  1  misaligned redirect flag (present only with TINKER_FETCH_ALIGN_CHECK_EN)

Function
REQ-003 SHALL implement states FETCH (byte counter k=0..3), LAST, OUT, HALT (plus FAULT when REQ-017 applies).
REQ-004 In FETCH: mem_rd_en=1, mem_addr=pc+k modulo 2^64; k increments each cycle; after k=3 go to LAST.
REQ-005 SHALL capture mem_rd_data the cycle after each request, little-endian: byte at pc+k to inst[8k+7:8k].
REQ-006 In LAST: mem_rd_en=0, capture byte 3, then go to OUT.
REQ-007 In OUT: inst_valid=1, inst and inst_pc=pc held stable until transfer.
REQ-008 Transfer occurs when inst_valid and inst_ready both high at a rising edge; then pc<=pc+4 (wraps modulo 2^64), k<=0, state FETCH.
REQ-009 Latency: inst_valid SHALL first assert exactly 5 cycles after the cycle issuing byte 0; with inst_ready held high, one instruction per 6 cycles.
REQ-010 inst_valid SHALL be 0 in FETCH, LAST, HALT, FAULT; mem_rd_en 0 outside FETCH.
REQ-011 redirect_valid high at an edge in FETCH/LAST/OUT: pc<=redirect_pc, k<=0, state FETCH; in-flight bytes discarded; held instruction dropped.
REQ-012 Redirect coincident with transfer: transfer counts as consumed, next pc from redirect_pc, not pc+4.
REQ-013 hlt high at an edge in any non-reset condition: state HALT; hlt takes priority over redirect and transfer.
REQ-014 HALT is absorbing until reset; no memory reads issued.
REQ-015 Behaviour SHALL not depend on inst_ready outside OUT.

Reset
REQ-016 reset high at an edge, in any state including mid-fetch: state FETCH, k=0, pc=RESET_PC, inst=0, inst_pc=RESET_PC, inst_valid=0, fetch_fault=0; mem_rd_en=1 and mem_addr=RESET_PC in first cycle after reset deasserts; reset overrides hlt and redirect.

Configuration
REQ-017 With TINKER_FETCH_ALIGN_CHECK_EN defined: fetch_fault port exists; redirect with redirect_pc[1:0]!=0 enters FAULT: no reads, inst_valid=0, fetch_fault=1 sticky until reset; hlt still enters HALT with fetch_fault held.
REQ-018 Without TINKER_FETCH_ALIGN_CHECK_EN: no fetch_fault port, no FAULT state; redirect_pc[1:0] forced to 2'b00.

Verification
REQ-019 Reset release, memory bytes 0x2000..0x2003 = 78 56 34 12, inst_ready=1 -> mem_addr 2000,2001,2002,2003 in cycles 0-3, inst_valid in cycle 5 with inst=32'h12345678, inst_pc=2000, next mem_addr=2004.
REQ-020 inst_ready=0 for 10 cycles during OUT -> inst, inst_pc stable, mem_rd_en=0; ready raised -> fetch of pc+4 starts next cycle.
REQ-021 redirect_valid with redirect_pc=64'h3000 during FETCH k=2 -> next cycle mem_addr=3000, k=0; first instruction delivered has inst_pc=3000, old bytes absent.
REQ-022 hlt and redirect_valid asserted together in OUT -> HALT next cycle, inst_valid=0, mem_rd_en=0 indefinitely; reset -> fetch resumes at 2000.
REQ-023 redirect_pc=64'hFFFF_FFFF_FFFF_FFFC, then transfer -> next fetch mem_addr=0 (wrap).
REQ-024 With TINKER_FETCH_ALIGN_CHECK_EN, redirect_pc=64'h3002 -> fetch_fault=1 next cycle, no reads; without macro, same stimulus -> fetch from 3000.

Source files
------------

// File: rtl/tinker_fetch_if.sv
// -----------------------------------------------------------------------------
// tinker_fetch_if
// Bus bundle between the tinker fetch stage and its neighbours.
//   memory side : mem_rd_en, mem_addr (fetch -> memory), mem_rd_data (memory -> fetch;
//                 the byte arrives the cycle after the request)
//   decode side : inst_valid, inst, inst_pc (fetch -> decode), inst_ready (decode -> fetch)
//   control     : redirect_valid, redirect_pc (control-flow change into fetch)
// Modports:
//   master - the fetch unit itself
//   slave  - the environment (memory, decode, redirect source)
// -----------------------------------------------------------------------------
interface tinker_fetch_if;
  logic        mem_rd_en;
  logic [63:0] mem_addr;
  logic [7:0]  mem_rd_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  modport master (
    output mem_rd_en, mem_addr, inst_valid, inst, inst_pc,
    input  mem_rd_data, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_rd_en, mem_addr, inst_valid, inst, inst_pc,
    output mem_rd_data, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/tinker_fetch.sv
// -----------------------------------------------------------------------------
// tinker_fetch
// Byte-serial instruction fetch. Reads four bytes (pc..pc+3) from a one-byte
// memory port, assembles them little-endian into a 32-bit word and offers it
// to decode with a valid/ready handshake. Supports redirect and halt.
//
// Ports:
//   clk          - sole clock, rising edge
//   reset        - synchronous, active-high
//   hlt          - halt request; fetch stops until reset
//   bus          - tinker_fetch_if.master (memory read port, decode handshake,
//                  redirect request)
//   fetch_fault  - sticky misaligned-redirect flag (only when
//                  TINKER_FETCH_ALIGN_CHECK_EN is defined)
//
// Configuration macro: TINKER_FETCH_ALIGN_CHECK_EN
//   defined   : misaligned redirect enters FAULT (no reads, fetch_fault=1)
//   undefined : redirect_pc[1:0] is ignored (forced to 2'b00)
// -----------------------------------------------------------------------------
module tinker_fetch #(
  parameter logic [63:0] RESET_PC = 64'h2000
) (
  input  logic clk,
  input  logic reset,
  input  logic hlt,
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
  output logic fetch_fault,
`endif
  tinker_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_LAST,
    S_OUT,
    S_HALT
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
    , S_FAULT
`endif
  } state_t;

  state_t      state, state_d;
  logic [1:0]  k, k_d;          // byte index of the request issued this cycle
  logic [63:0] pc, pc_d;
  logic [31:0] inst_q;
  logic [1:0]  cap_idx;
  logic [63:0] redir_pc;
  logic        rd_en;
  logic        valid;
  logic        redir_ok;

`ifdef TINKER_FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
`endif

  // Instructions are word aligned; the low two bits never reach the pc.
  assign redir_pc = bus.redirect_pc & ~64'd3;
  assign redir_ok = bus.redirect_valid &&
                    (state == S_FETCH || state == S_LAST || state == S_OUT);

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can leave
    // it unassigned and infer a latch.
    state_d = state;
    k_d     = k;
    pc_d    = pc;
    rd_en   = 1'b0;
    valid   = 1'b0;
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
    fault_d = fault_q;
`endif

    case (state)
      S_FETCH: begin
        rd_en = 1'b1;
        k_d   = k + 2'd1;
        if (k == 2'd3) state_d = S_LAST;
      end
      S_LAST: state_d = S_OUT;
      S_OUT: begin
        valid = 1'b1;
        if (bus.inst_ready) begin
          pc_d    = pc + 64'd4;
          k_d     = 2'd0;
          state_d = S_FETCH;
        end
      end
      default: ; // HALT and FAULT hold until reset (HALT reachable via hlt)
    endcase

    // A redirect overrides the normal sequence; a coincident transfer has
    // already been consumed by decode, so only the next pc changes.
    if (redir_ok) begin
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
      if (|bus.redirect_pc[1:0]) begin
        state_d = S_FAULT;
        fault_d = 1'b1;
      end else begin
`else
      begin
`endif
        pc_d    = redir_pc;
        k_d     = 2'd0;
        state_d = S_FETCH;
      end
    end

    // Halt wins over redirect and transfer.
    if (hlt) state_d = S_HALT;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state   <= S_FETCH;
      k       <= 2'd0;
      pc      <= RESET_PC;
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      k       <= k_d;
      pc      <= pc_d;
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Byte capture: the byte requested at index k arrives one cycle later, so in
  // FETCH with k>0 we store byte k-1, and in LAST we store byte 3. Partially
  // assembled words from an abandoned fetch are always fully overwritten
  // before the next OUT, so no explicit flush is needed.
  // ---------------------------------------------------------------------------
  assign cap_idx = k - 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q <= '0;
    end else if (state == S_FETCH && k != 2'd0) begin
      inst_q[{cap_idx, 3'b000} +: 8] <= bus.mem_rd_data;
    end else if (state == S_LAST) begin
      inst_q[31:24] <= bus.mem_rd_data;
    end
  end

  assign bus.mem_rd_en  = rd_en;
  assign bus.mem_addr   = pc + {62'd0, k};
  assign bus.inst_valid = valid;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = pc;
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
  assign fetch_fault    = fault_q;
`endif

endmodule

// File: tb/tb_tinker_fetch.sv
// -----------------------------------------------------------------------------
// tb_tinker_fetch
// Self-checking bench for tinker_fetch. A behavioural byte memory answers read
// requests one cycle later; expected instructions are pushed to a scoreboard
// queue when stimulus makes them due and are popped by a monitor on every
// decode transfer. Redirect scenarios come from a vector table; reset, stall,
// halt and fault behaviour use hand-written sequences.
// Inputs are driven 1ns after the falling edge; the monitor samples 3ns after
// the falling edge, both well away from the rising (active) edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tinker_fetch;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic hlt   = 1'b0;
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
  logic fetch_fault;
`endif

  tinker_fetch_if bus ();

  tinker_fetch #(.RESET_PC(64'h2000)) dut (
    .clk        (clk),
    .reset      (reset),
    .hlt        (hlt),
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
    .fetch_fault(fetch_fault),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } exp_t;

  typedef struct {
    logic [63:0] target;       // redirect_pc applied
    int          delay;        // cycles after FETCH k=0 (0-3 FETCH, 4 LAST, 5 OUT)
    logic        ready;        // inst_ready during the window before the redirect
    logic        consumed_old; // instruction at the old pc is transferred too
    logic [63:0] exp_pc;       // first pc expected to be delivered afterwards
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [63:0] cur_pc;
  vec_t        vecs[$];

  // ---------------------------------------------------------------------------
  // Reference memory contents
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    case (a)
      64'h2000: return 8'h78;
      64'h2001: return 8'h56;
      64'h2002: return 8'h34;
      64'h2003: return 8'h12;
      default:  return a[7:0] ^ a[15:8] ^ a[63:56] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {mem_byte(a + 64'd3), mem_byte(a + 64'd2), mem_byte(a + 64'd1), mem_byte(a)};
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] i, input logic [63:0] p);
    exp_t e;
    e.inst = i;
    e.pc   = p;
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic [63:0] t, input int d, input logic r,
                                  input logic c, input logic [63:0] e);
    vec_t v;
    v.target = t; v.delay = d; v.ready = r; v.consumed_old = c; v.exp_pc = e;
    return v;
  endfunction

  // Memory: byte valid the cycle after the request; idle cycles return junk.
  always @(posedge clk)
    bus.mem_rd_data <= bus.mem_rd_en ? mem_byte(bus.mem_addr) : 8'hEE;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transfer monitor / scoreboard consumer.
  always begin
    @(negedge clk);
    #3;
    if (!reset && !hlt && bus.inst_valid && bus.inst_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL xfer_unexpected: actual pc %h required no transfer", bus.inst_pc);
      end else begin
        mon_e = sb.pop_front();
        check("xfer_inst", {32'd0, bus.inst}, {32'd0, mon_e.inst});
        check("xfer_pc", bus.inst_pc, mon_e.pc);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Bounded wait for all scoreboard entries to be transferred; ends in the
  // first cycle after the last transfer.
  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    check(name, 64'(sb.size()), 64'd0);
    if (sb.size() != 0) sb.delete();
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_inst"},    {32'd0, bus.inst}, 64'd0);
    check({name, "_inst_pc"}, bus.inst_pc, 64'h2000);
    check({name, "_valid"},   64'(bus.inst_valid), 64'd0);
    check({name, "_rd_en"},   64'(bus.mem_rd_en), 64'd1);
    check({name, "_addr"},    bus.mem_addr, 64'h2000);
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
    check({name, "_fault"},   64'(fetch_fault), 64'd0);
`endif
  endtask

  initial begin
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    vecs.push_back(mk_vec(64'h3000, 2, 1'b1, 1'b0, 64'h3000));
    vecs.push_back(mk_vec(64'h4000, 0, 1'b0, 1'b0, 64'h4000));
    vecs.push_back(mk_vec(64'h5008, 4, 1'b1, 1'b0, 64'h5008));
    vecs.push_back(mk_vec(64'h6000, 5, 1'b0, 1'b0, 64'h6000));
    vecs.push_back(mk_vec(64'h6100, 5, 1'b1, 1'b1, 64'h6100));
    vecs.push_back(mk_vec(64'h1234_5678_9ABC_DEF0, 1, 1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0));
    vecs.push_back(mk_vec(64'hFFFF_FFFF_FFFF_FFFC, 3, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC));
`ifndef TINKER_FETCH_ALIGN_CHECK_EN
    vecs.push_back(mk_vec(64'h3002, 1, 1'b1, 1'b0, 64'h3000));
`endif

    // ---- Reset release and first fetch -------------------------------------
    bus.inst_ready = 1'b1;
    sb.push_back(mk_exp(32'h1234_5678, 64'h2000));
    do_reset();
    check_reset_state("rst0");
    for (int c = 0; c < 4; c++) begin
      check("a_rd_en", 64'(bus.mem_rd_en), 64'd1);
      check("a_addr", bus.mem_addr, 64'h2000 + 64'(c));
      check("a_valid_early", 64'(bus.inst_valid), 64'd0);
      tick();
    end
    check("a_last_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("a_last_valid", 64'(bus.inst_valid), 64'd0);
    tick();
    check("a_out_valid", 64'(bus.inst_valid), 64'd1);
    check("a_out_inst", {32'd0, bus.inst}, 64'h1234_5678);
    check("a_out_pc", bus.inst_pc, 64'h2000);
    tick();
    check("a_next_rd_en", 64'(bus.mem_rd_en), 64'd1);
    check("a_next_addr", bus.mem_addr, 64'h2004);

    // ---- Decode stall in OUT ----------------------------------------------
    bus.inst_ready = 1'b0;
    sb.push_back(mk_exp(mem_word(64'h2004), 64'h2004));
    for (int i = 0; i < 20 && !bus.inst_valid; i++) tick();
    check("b_valid", 64'(bus.inst_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("b_hold_inst", {32'd0, bus.inst}, {32'd0, mem_word(64'h2004)});
      check("b_hold_pc", bus.inst_pc, 64'h2004);
      check("b_hold_rd_en", 64'(bus.mem_rd_en), 64'd0);
      if (i < 9) tick();
    end
    bus.inst_ready = 1'b1;
    tick();
    check("b_resume_rd_en", 64'(bus.mem_rd_en), 64'd1);
    check("b_resume_addr", bus.mem_addr, 64'h2008);
    check("b_sb", 64'(sb.size()), 64'd0);
    cur_pc = 64'h2008;

    // ---- Redirect vectors ------------------------------------------------
    foreach (vecs[i]) begin
      bus.inst_ready = vecs[i].ready;
      if (vecs[i].consumed_old) sb.push_back(mk_exp(mem_word(cur_pc), cur_pc));
      repeat (vecs[i].delay) tick();
      if (vecs[i].delay == 5) check("v_out_valid", 64'(bus.inst_valid), 64'd1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = vecs[i].target;
      tick();
      bus.redirect_valid = 1'b0;
      bus.inst_ready     = 1'b1;
      check("v_addr", bus.mem_addr, vecs[i].exp_pc);
      check("v_rd_en", 64'(bus.mem_rd_en), 64'd1);
      check("v_valid", 64'(bus.inst_valid), 64'd0);
      sb.push_back(mk_exp(mem_word(vecs[i].exp_pc), vecs[i].exp_pc));
      wait_drain("v_drain");
      check("v_next_addr", bus.mem_addr, vecs[i].exp_pc + 64'd4);
      cur_pc = vecs[i].exp_pc + 64'd4;
    end

    // ---- Halt together with redirect in OUT -------------------------------
    bus.inst_ready = 1'b0;
    repeat (5) tick();
    check("h_out_valid", 64'(bus.inst_valid), 64'd1);
    check("h_out_pc", bus.inst_pc, cur_pc);
    hlt                = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h7000;
    bus.inst_ready     = 1'b1;
    tick();
    hlt                = 1'b0;
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("h_valid", 64'(bus.inst_valid), 64'd0);
      check("h_rd_en", 64'(bus.mem_rd_en), 64'd0);
      bus.redirect_valid = i[0];
      tick();
    end
    // Reset with hlt and redirect still asserted: reset must win.
    hlt                = 1'b1;
    bus.redirect_valid = 1'b1;
    reset              = 1'b1;
    tick();
    tick();
    reset              = 1'b0;
    hlt                = 1'b0;
    bus.redirect_valid = 1'b0;
    check_reset_state("rst1");
    sb.push_back(mk_exp(32'h1234_5678, 64'h2000));
    wait_drain("h_drain");
    check("h_next_addr", bus.mem_addr, 64'h2004);

`ifdef TINKER_FETCH_ALIGN_CHECK_EN
    // ---- Misaligned redirect -> FAULT ------------------------------------
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h3002;
    tick();
    bus.redirect_pc    = 64'h4000;
    check("f_fault", 64'(fetch_fault), 64'd1);
    check("f_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("f_valid", 64'(bus.inst_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("f_sticky", 64'(fetch_fault), 64'd1);
      check("f_sticky_rd_en", 64'(bus.mem_rd_en), 64'd0);
    end
    bus.redirect_valid = 1'b0;
    hlt = 1'b1;
    tick();
    hlt = 1'b0;
    tick();
    check("f_halt_fault", 64'(fetch_fault), 64'd1);
    check("f_halt_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("f_halt_valid", 64'(bus.inst_valid), 64'd0);
    do_reset();
    check_reset_state("rst2");
`endif

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
